seq_alu: RTL and testbench

Multi-cycle execution unit that consumes the 4-bit ALU control code produced by the core's ALU control decoder and returns a result plus a branch-condition flag. It sits in the execute stage of the multi-cycle core variant, between the register-file/immediate operand muxes and the writeback/PC-select logic. Shifts are performed iteratively, one bit per cycle. All other operations complete in a single compute cycle. Operands arrive and results leave over valid/ready handshakes.

---
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu.sv | 191 +++++++++++++++++++
 tb/tb_seq_alu.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Handshake bundle between the operand muxes (master) and seq_alu (slave).
// Request side: in_valid/in_ready with alu_control and operands.
// Response side: out_valid/out_ready with result and branch_taken.
interface seq_alu_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, branch_taken
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, branch_taken
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Shifts run one bit per cycle; everything else completes in one compute cycle.
// Build option SEQ_ALU_FAST_SHIFT_EN: shifts use a barrel shifter, every code takes
// one cycle and the SHIFT state and bit counter disappear. Results are identical.
// XLEN must match the XLEN of the connected seq_alu_if.
module seq_alu #(
  parameter int unsigned XLEN = 32
) (
  input logic      clk,
  input logic      reset,
  seq_alu_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpSll = 4'h2;
  localparam logic [3:0] OpLt  = 4'h3;
  localparam logic [3:0] OpLtu = 4'h4;
  localparam logic [3:0] OpXor = 4'h5;
  localparam logic [3:0] OpSra = 4'h6;
  localparam logic [3:0] OpSrl = 4'h7;
  localparam logic [3:0] OpOr  = 4'h8;
  localparam logic [3:0] OpAnd = 4'h9;
  localparam logic [3:0] OpEq  = 4'ha;
  localparam logic [3:0] OpNe  = 4'hb;
  localparam logic [3:0] OpGe  = 4'hc;
  localparam logic [3:0] OpGeu = 4'hd;

`ifdef SEQ_ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  localparam logic [SHW-1:0] CntOne = SHW'(1);
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            branch_q, branch_d;
  logic [XLEN-1:0] calc_res;
  logic            calc_br;
  logic [SHW-1:0]  amt;
  logic            accept;

  assign amt    = bus.src_b[SHW-1:0];
  assign accept = bus.in_valid && (state_q == StIdle);

`ifndef SEQ_ALU_FAST_SHIFT_EN
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] acc_step;
  logic            is_shift;

  assign is_shift = (bus.alu_control == OpSll) || (bus.alu_control == OpSra) ||
                    (bus.alu_control == OpSrl);

  // One-bit shift of the accumulator in the direction/type of the latched code.
  always_comb begin
    acc_step = acc_q >> 1;
    case (op_q)
      OpSll:   acc_step = acc_q << 1;
      OpSra:   acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: acc_step = acc_q >> 1;
    endcase
  end
`endif

  // Single-cycle result for the code currently presented at the inputs.
  always_comb begin
    calc_res = '0;
    calc_br  = 1'b0;
    case (bus.alu_control)
      OpAdd: calc_res = bus.src_a + bus.src_b;
      OpSub: calc_res = bus.src_a - bus.src_b;
      OpXor: calc_res = bus.src_a ^ bus.src_b;
      OpOr:  calc_res = bus.src_a | bus.src_b;
      OpAnd: calc_res = bus.src_a & bus.src_b;
`ifdef SEQ_ALU_FAST_SHIFT_EN
      OpSll: calc_res = bus.src_a << amt;
      OpSrl: calc_res = bus.src_a >> amt;
      OpSra: calc_res = XLEN'($signed(bus.src_a) >>> amt);
`else
      // Only reached with amount 0 here; nonzero amounts go through SHIFT.
      OpSll, OpSrl, OpSra: calc_res = bus.src_a;
`endif
      OpLt:  calc_br = $signed(bus.src_a) < $signed(bus.src_b);
      OpLtu: calc_br = bus.src_a < bus.src_b;
      OpEq:  calc_br = bus.src_a == bus.src_b;
      OpNe:  calc_br = bus.src_a != bus.src_b;
      OpGe:  calc_br = $signed(bus.src_a) >= $signed(bus.src_b);
      OpGeu: calc_br = bus.src_a >= bus.src_b;
      default: ;
    endcase
    if (calc_br) calc_res = {{(XLEN-1){1'b0}}, 1'b1};
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
          state_d = StDone;
`else
          state_d = (is_shift && (amt != '0)) ? StShift : StDone;
`endif
        end
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      StShift: if (cnt_q == CntOne) state_d = StDone;
`endif
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: latch on accept, step the shifter, hold in DONE.
  always_comb begin
    result_d = result_q;
    branch_d = branch_q;
`ifndef SEQ_ALU_FAST_SHIFT_EN
    op_d  = op_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
`endif
    if (accept) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
      result_d = calc_res;
      branch_d = calc_br;
`else
      op_d  = bus.alu_control;
      acc_d = bus.src_a;
      cnt_d = amt;
      if (!(is_shift && (amt != '0))) begin
        result_d = calc_res;
        branch_d = calc_br;
      end
`endif
    end
`ifndef SEQ_ALU_FAST_SHIFT_EN
    else if (state_q == StShift) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        result_d = acc_step;
        branch_d = 1'b0;
      end
    end
`endif
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      branch_q <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      op_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
      result_q <= result_d;
      branch_q <= branch_d;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      op_q  <= op_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
`endif
    end
  end

  // Handshake outputs decoded from state; result fields come straight from registers.
  always_comb begin
    bus.in_ready     = (state_q == StIdle);
    bus.out_valid    = (state_q == StDone);
    bus.result       = result_q;
    bus.branch_taken = branch_q;
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a reference model computes each result from the operation
// rules, and a compare process checks the response every cycle an operation is in flight.
module tb_seq_alu;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;

  seq_alu_if #(.XLEN(XLEN)) bus ();

  seq_alu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] res;
    logic        br;
  } vec_t;

  // Monitor state, armed by the driver right after each accept edge.
  logic        mon_active = 1'b0;
  logic        mon_seen = 1'b0;
  logic        mon_late = 1'b0;
  int          mon_cyc = 0;
  int          mon_lat = 0;
  logic [31:0] mon_res = '0;
  logic        mon_br = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written straight from the operation table.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic br);
    int unsigned amt;
    amt = b[4:0];
    r = 32'd0;
    br = 1'b0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a << amt;
      4'h3: br = $signed(a) < $signed(b);
      4'h4: br = a < b;
      4'h5: r = a ^ b;
      4'h6: r = $signed(a) >>> amt;
      4'h7: r = a >> amt;
      4'h8: r = a | b;
      4'h9: r = a & b;
      4'ha: br = a == b;
      4'hb: br = a != b;
      4'hc: br = $signed(a) >= $signed(b);
      4'hd: br = a >= b;
      default: ;
    endcase
    if (op inside {4'h3, 4'h4, 4'ha, 4'hb, 4'hc, 4'hd}) r = {31'd0, br};
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b);
`ifdef SEQ_ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'h2 || op == 4'h6 || op == 4'h7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Compare process: latency, busy in_ready and stable model-matching result every cycle.
  always @(negedge clk) begin
    if (mon_active) begin
      mon_cyc++;
      check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      if (bus.out_valid) begin
        if (!mon_seen) check("latency", mon_cyc, mon_lat);
        mon_seen = 1'b1;
        check("result", bus.result, mon_res);
        check("branch_taken", {31'd0, bus.branch_taken}, {31'd0, mon_br});
      end else if (mon_seen) begin
        check("out_valid_dropped_early", 32'd0, 32'd1);
      end else if (mon_cyc > mon_lat && !mon_late) begin
        mon_late = 1'b1;
        check("latency_late", mon_cyc, mon_lat);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // Present one request at a negedge; returns just after the accept edge.
  task automatic accept_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    // Scramble inputs: the latched operation must be unaffected.
    bus.alu_control = 4'($urandom);
    bus.src_a       = $urandom;
    bus.src_b       = $urandom;
  endtask

  task automatic run_op(input vec_t v);
    logic [31:0] r;
    logic        br;
    int          n;
    model(v.op, v.a, v.b, r, br);
    check("model_pin_res", r, v.res);
    check("model_pin_br", {31'd0, br}, {31'd0, v.br});
    accept_op(v.op, v.a, v.b);
    mon_res = r;
    mon_br = br;
    mon_lat = latency(v.op, v.b);
    mon_cyc = 0;
    mon_seen = 1'b0;
    mon_late = 1'b0;
    mon_active = 1'b1;
    n = 0;
    while (!mon_seen && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (!mon_seen) check("out_valid_timeout", 32'd0, 32'd1);
    repeat (v.hold) @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    mon_active = 1'b0;
    @(negedge clk);
    check("post_handshake_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("post_handshake_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic saw_valid;
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'h0;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.out_ready   = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_branch", {31'd0, bus.branch_taken}, 32'd0);

    vecs.push_back('{4'h0, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 1'b0});
    vecs.push_back('{4'h6, 32'h80000010, 32'h00000024, 0, 32'hF8000001, 1'b0});
    vecs.push_back('{4'h3, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000001, 1'b1});
    vecs.push_back('{4'h4, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1'b0});
    vecs.push_back('{4'hc, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1'b0});
    vecs.push_back('{4'hd, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000001, 1'b1});
    vecs.push_back('{4'ha, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1'b0});
    vecs.push_back('{4'hb, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000001, 1'b1});
    vecs.push_back('{4'h5, 32'hF0F0F0F0, 32'hFFFF0000, 10, 32'h0F0FF0F0, 1'b0});
    vecs.push_back('{4'h7, 32'h12345678, 32'h00000020, 0, 32'h12345678, 1'b0});
    vecs.push_back('{4'he, 32'h12345678, 32'h00000020, 0, 32'h00000000, 1'b0});
    vecs.push_back('{4'hf, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000000, 1'b0});
    vecs.push_back('{4'h1, 32'h00000000, 32'h00000001, 0, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{4'h2, 32'h00000001, 32'h0000001F, 2, 32'h80000000, 1'b0});
    vecs.push_back('{4'h7, 32'h80000000, 32'hFFFFFFE1, 0, 32'h40000000, 1'b0});
    vecs.push_back('{4'h8, 32'h0000FF00, 32'h00F000F0, 0, 32'h00F0FFF0, 1'b0});
    vecs.push_back('{4'h9, 32'h0000FF00, 32'h00F0F0F0, 0, 32'h0000F000, 1'b0});
    vecs.push_back('{4'ha, 32'h00000005, 32'h00000005, 0, 32'h00000001, 1'b1});

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset in the middle of a long shift discards it without any out_valid.
    accept_op(4'h2, 32'h00000001, 32'h0000001F);
    saw_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midreset_result", bus.result, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("midreset_no_out_valid", {31'd0, saw_valid}, 32'd0);
    run_op('{4'h0, 32'h00000002, 32'h00000003, 0, 32'h00000005, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
